// File: rtl/red_pitaya_ramped_gain_block.sv
// Ramped proportional gain stage: signed DW-bit sample times a slew-limited
// GAINBITS-bit gain, rounded half up, saturated, with a clip event counter.
// Configured over the 16-bit-address PS register bus.
`timescale 1ns/1ps
module red_pitaya_ramped_gain_block #(
  parameter int DW       = 14,
  parameter int GAINBITS = 24,
  parameter int PSR      = 12,
  parameter int DIVBITS  = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic signed [DW-1:0] dat_i,
  output logic signed [DW-1:0] dat_o,
  input  logic [15:0]         addr,
  input  logic                wen,
  input  logic                ren,
  input  logic [31:0]         wdata,
  output logic                ack,
  output logic [31:0]         rdata
);

  localparam int PW = DW + GAINBITS;   // full product width
  localparam int RW = PW + 1;          // headroom for the rounding offset

  localparam logic signed [RW-1:0] RND_HALF = {{(RW-1){1'b0}}, 1'b1} << (PSR - 1);
  localparam logic signed [RW-1:0] SAT_MAX  = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN  = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RAMP = 1'b1} ramp_state_t;

  ramp_state_t                 state_r, state_s;
  logic signed [GAINBITS-1:0]  kp_target_r, kp_cur_r, kp_cur_s;
  logic [GAINBITS-2:0]         ramp_step_r;
  logic [DIVBITS-1:0]          ramp_div_r, div_cnt_r, div_cnt_s;
  logic [15:0]                 sat_count_r;

  logic signed [GAINBITS:0]    diff_s;
  logic [GAINBITS:0]           diff_abs_s, step_ext_s;
  logic signed [GAINBITS-1:0]  kp_up_s, kp_dn_s;

  logic signed [DW-1:0]        dat_r;
  logic signed [GAINBITS-1:0]  kp_r;
  logic signed [PW-1:0]        prod_r;
  logic signed [RW-1:0]        sum_s, rnd_s;
  logic signed [DW-1:0]        dat_sat_s;
  logic                        clip_s;
  logic [31:0]                 rd_mux_s;
  logic                        unused_wdata_s;

  assign unused_wdata_s = ^wdata;

  // Distance to target in one extra bit so the subtraction cannot overflow.
  assign diff_s     = {kp_target_r[GAINBITS-1], kp_target_r} - {kp_cur_r[GAINBITS-1], kp_cur_r};
  assign diff_abs_s = diff_s[GAINBITS] ? -diff_s : diff_s;
  assign step_ext_s = {2'b00, ramp_step_r};
  assign kp_up_s    = kp_cur_r + {1'b0, ramp_step_r};
  assign kp_dn_s    = kp_cur_r - {1'b0, ramp_step_r};

  // Ramp FSM state, divider and current gain registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= {DIVBITS{1'b0}};
      kp_cur_r  <= {GAINBITS{1'b0}};
    end else begin
      state_r   <= state_s;
      div_cnt_r <= div_cnt_s;
      kp_cur_r  <= kp_cur_s;
    end
  end

  // Ramp next-state: immediate follow when step is zero, else paced steps.
  always_comb begin
    state_s   = state_r;
    div_cnt_s = div_cnt_r;
    kp_cur_s  = kp_cur_r;
    case (state_r)
      ST_IDLE: begin
        if (ramp_step_r == {(GAINBITS-1){1'b0}}) begin
          kp_cur_s = kp_target_r;
        end else if (diff_s != {(GAINBITS+1){1'b0}}) begin
          state_s   = ST_RAMP;
          div_cnt_s = ramp_div_r;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (div_cnt_r != {DIVBITS{1'b0}}) begin
          div_cnt_s = div_cnt_r - {{(DIVBITS-1){1'b0}}, 1'b1};
        end else begin
          div_cnt_s = ramp_div_r;
          // A zero step mid-ramp lands directly rather than stalling forever.
          if ((diff_abs_s <= step_ext_s) || (ramp_step_r == {(GAINBITS-1){1'b0}})) begin
            kp_cur_s = kp_target_r;
            state_s  = ST_IDLE;
          end else if (diff_s[GAINBITS]) begin
            kp_cur_s = kp_dn_s;
          end else begin
            kp_cur_s = kp_up_s;
          end
        end
      end
      default: begin
        state_s   = ST_IDLE;
        div_cnt_s = {DIVBITS{1'b0}};
      end
    endcase
  end

  // Three-stage datapath: operand capture, multiply, round/saturate.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dat_r  <= {DW{1'b0}};
      kp_r   <= {GAINBITS{1'b0}};
      prod_r <= {PW{1'b0}};
      dat_o  <= {DW{1'b0}};
    end else begin
      dat_r  <= dat_i;
      kp_r   <= kp_cur_r;
      prod_r <= PW'(dat_r) * PW'(kp_r);
      dat_o  <= dat_sat_s;
    end
  end

  // Round half up, then clip to the signed DW-bit range.
  always_comb begin
    sum_s     = RW'(prod_r) + RND_HALF;
    rnd_s     = sum_s >>> PSR;
    clip_s    = 1'b0;
    dat_sat_s = rnd_s[DW-1:0];
    if (rnd_s > SAT_MAX) begin
      dat_sat_s = SAT_MAX[DW-1:0];
      clip_s    = 1'b1;
    end else if (rnd_s < SAT_MIN) begin
      dat_sat_s = SAT_MIN[DW-1:0];
      clip_s    = 1'b1;
    end else begin
      dat_sat_s = rnd_s[DW-1:0];
    end
  end

  // Read mux over current register values (a same-cycle write is not seen).
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (addr)
      16'h0108: rd_mux_s = 32'(kp_target_r);
      16'h010C: rd_mux_s = 32'(ramp_step_r);
      16'h0110: rd_mux_s = 32'(ramp_div_r);
      16'h0114: rd_mux_s = {31'h0000_0000, state_r == ST_RAMP};
      16'h0118: rd_mux_s = 32'(kp_cur_r);
      16'h011C: rd_mux_s = {16'h0000, sat_count_r};
      16'h0200: rd_mux_s = 32'(PSR);
      16'h020C: rd_mux_s = 32'(GAINBITS);
      16'h0210: rd_mux_s = 32'(DW);
      default:  rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Bus handshake, configuration registers and clip counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack         <= 1'b0;
      rdata       <= 32'h0000_0000;
      kp_target_r <= {GAINBITS{1'b0}};
      ramp_step_r <= {(GAINBITS-1){1'b0}};
      ramp_div_r  <= {DIVBITS{1'b0}};
      sat_count_r <= 16'h0000;
    end else begin
      ack   <= wen | ren;
      rdata <= ren ? rd_mux_s : 32'h0000_0000;
      if (wen) begin
        case (addr)
          16'h0108: kp_target_r <= wdata[GAINBITS-1:0];
          16'h010C: ramp_step_r <= wdata[GAINBITS-2:0];
          16'h0110: ramp_div_r  <= wdata[DIVBITS-1:0];
          default:  ;
        endcase
      end
      // A clearing write wins over a simultaneous clip event.
      if (wen && (addr == 16'h011C)) begin
        sat_count_r <= 16'h0000;
      end else if (clip_s && (sat_count_r != 16'hFFFF)) begin
        sat_count_r <= sat_count_r + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_ramped_gain_block.sv
// Directed bench for red_pitaya_ramped_gain_block with hand-computed expectations.
`timescale 1ns/1ps
module tb_red_pitaya_ramped_gain_block;

  logic               clk_i;
  logic               rstn_i;
  logic signed [13:0] dat_i;
  logic signed [13:0] dat_o;
  logic [15:0]        addr;
  logic               wen;
  logic               ren;
  logic [31:0]        wdata;
  logic               ack;
  logic [31:0]        rdata;

  int checks;
  int failures;
  logic [31:0] v;

  red_pitaya_ramped_gain_block dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .addr  (addr),
    .wen   (wen),
    .ren   (ren),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata)
  );

  // Free-running 100 MHz clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    @(negedge clk_i);
    wen = 1'b0; addr = 16'h0000; wdata = 32'h0000_0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    @(negedge clk_i);
    ren = 1'b0; addr = 16'h0000;
    d = rdata;
  endtask

  task automatic wr_rd(input logic [15:0] a, input logic [31:0] dw, output logic [31:0] d);
    addr = a; wdata = dw; wen = 1'b1; ren = 1'b1;
    @(negedge clk_i);
    wen = 1'b0; ren = 1'b0; addr = 16'h0000; wdata = 32'h0000_0000;
    d = rdata;
  endtask

  initial begin
    checks = 0; failures = 0;
    rstn_i = 1'b0; dat_i = 14'sd0; addr = 16'h0000; wen = 1'b0; ren = 1'b0; wdata = 32'h0000_0000;
    repeat (3) @(negedge clk_i);
    check_val("rst_dat_o", 32'(dat_o), 32'h0);
    check_val("rst_ack", {31'h0, ack}, 32'h0);
    check_val("rst_rdata", rdata, 32'h0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    rd(16'h0200, v); check_val("const_psr", v, 32'd12);
    rd(16'h020C, v); check_val("const_gainbits", v, 32'd24);
    rd(16'h0210, v); check_val("const_dw", v, 32'd14);
    rd(16'h0118, v); check_val("rst_kp_cur", v, 32'h0);

    // Unity gain, immediate mode.
    dat_i = 14'sd1000;
    wr(16'h0108, 32'h0000_1000);
    repeat (3) @(negedge clk_i);
    check_val("unity_latency_pre", 32'(dat_o), 32'h0);
    @(negedge clk_i);
    check_val("unity_out", 32'(dat_o), 32'd1000);
    rd(16'h0114, v); check_val("unity_status", v, 32'h0);
    rd(16'h0118, v); check_val("unity_kp_cur", v, 32'h0000_1000);

    // Negative gain, sign-extended readback.
    wr(16'h0108, 32'hFFFF_F000);
    repeat (5) @(negedge clk_i);
    check_val("neg_unity_out", 32'(dat_o), 32'hFFFF_FC18);
    rd(16'h0108, v); check_val("kp_target_sext", v, 32'hFFFF_F000);

    // Half gain, round half up.
    dat_i = 14'sd3;
    wr(16'h0108, 32'h0000_0800);
    repeat (5) @(negedge clk_i);
    check_val("half_pos3", 32'(dat_o), 32'd2);
    dat_i = -14'sd3;
    repeat (4) @(negedge clk_i);
    check_val("half_neg3", 32'(dat_o), 32'hFFFF_FFFF);

    // Gain 4.0 with saturation and clip counting.
    dat_i = 14'sd0;
    wr(16'h0108, 32'h0000_4000);
    repeat (5) @(negedge clk_i);
    rd(16'h011C, v); check_val("sat_cnt_zero", v, 32'h0);
    dat_i = 14'sd8000;
    repeat (3) @(negedge clk_i);
    dat_i = -14'sd8192;
    check_val("sat_pos", 32'(dat_o), 32'd8191);
    repeat (3) @(negedge clk_i);
    dat_i = 14'sd0;
    check_val("sat_neg", 32'(dat_o), 32'hFFFF_E000);
    repeat (5) @(negedge clk_i);
    rd(16'h011C, v); check_val("sat_cnt_six", v, 32'd6);
    check_val("sat_zero_out", 32'(dat_o), 32'h0);
    dat_i = 14'sd8000;
    repeat (4) @(negedge clk_i);
    wr(16'h011C, 32'h0000_0000);
    rd(16'h011C, v); check_val("sat_clear_wins", v, 32'h0);
    dat_i = 14'sd0;

    // Ramp up 0 -> 0x1000 in 0x100 steps every 4 cycles.
    wr(16'h0108, 32'h0000_0000);
    @(negedge clk_i);
    wr_rd(16'h0110, 32'd3, v); check_val("rd_same_cycle_old", v, 32'h0);
    rd(16'h0110, v); check_val("ramp_div_rb", v, 32'd3);
    wr(16'h010C, 32'h0000_0100);
    wr(16'h0108, 32'h0000_1000);
    @(negedge clk_i);
    rd(16'h0114, v); check_val("up_ramping", v, 32'h1);
    repeat (4) @(negedge clk_i);
    rd(16'h0118, v); check_val("up_step1", v, 32'h0000_0100);
    repeat (3) @(negedge clk_i);
    rd(16'h0118, v); check_val("up_step2", v, 32'h0000_0200);
    repeat (53) @(negedge clk_i);
    rd(16'h0114, v); check_val("up_still_ramping", v, 32'h1);
    rd(16'h0114, v); check_val("up_done_idle", v, 32'h0);
    rd(16'h0118, v); check_val("up_final", v, 32'h0000_1000);

    // Ramp down toward 0, retarget to 0x400 at kp_cur = 0x800.
    wr(16'h0108, 32'h0000_0000);
    repeat (33) @(negedge clk_i);
    wr(16'h0108, 32'h0000_0400);
    rd(16'h0118, v); check_val("rev_at_800", v, 32'h0000_0800);
    repeat (2) @(negedge clk_i);
    rd(16'h0118, v); check_val("rev_step_700", v, 32'h0000_0700);
    repeat (11) @(negedge clk_i);
    rd(16'h0114, v); check_val("rev_idle", v, 32'h0);
    rd(16'h0118, v); check_val("rev_final", v, 32'h0000_0400);

    // Single clamped step 0x400 -> 0x500 with step 0x300.
    wr(16'h010C, 32'h0000_0300);
    wr(16'h0108, 32'h0000_0500);
    repeat (3) @(negedge clk_i);
    rd(16'h0114, v); check_val("clamp_ramping", v, 32'h1);
    rd(16'h0118, v); check_val("clamp_before", v, 32'h0000_0400);
    rd(16'h0118, v); check_val("clamp_landed", v, 32'h0000_0500);
    rd(16'h0114, v); check_val("clamp_idle", v, 32'h0);

    // Asynchronous reset mid-ramp.
    dat_i = 14'sd1000;
    wr(16'h010C, 32'h0000_0100);
    wr(16'h0108, 32'h0000_1000);
    repeat (10) @(negedge clk_i);
    addr = 16'h0114; ren = 1'b1;
    #7;
    check_val("pre_rst_ack", {31'h0, ack}, 32'h1);
    rstn_i = 1'b0;
    #1;
    check_val("async_rst_dat_o", 32'(dat_o), 32'h0);
    check_val("async_rst_ack", {31'h0, ack}, 32'h0);
    check_val("async_rst_rdata", rdata, 32'h0);
    ren = 1'b0; addr = 16'h0000; dat_i = 14'sd0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    rd(16'h0114, v); check_val("post_rst_status", v, 32'h0);
    rd(16'h0118, v); check_val("post_rst_kp_cur", v, 32'h0);

    // Unmapped read.
    addr = 16'h0300; ren = 1'b1;
    @(negedge clk_i);
    ren = 1'b0; addr = 16'h0000;
    check_val("unmapped_ack", {31'h0, ack}, 32'h1);
    check_val("unmapped_rdata", rdata, 32'h0);
    @(negedge clk_i);
    check_val("unmapped_ack_drop", {31'h0, ack}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/red_pitaya_ramped_gain_block.md
# red_pitaya_ramped_gain_block

Parametrised successor to the single-gain proportional stage: a signed data path with generic width and gain. It adds rounding and output saturation, a slew-limited (ramped) gain update so gain changes do not step the output, and a saturation event counter. The block sits between a DSP-mux input and output and is configured over the same 16-bit-address PS register bus as the other DSP blocks.

## Interface
- DW, 14: data width of dat_i/dat_o (signed)
- GAINBITS, 24: gain width (signed), max 31
- PSR, 12: gain binary point (gain 1.0 = 2^PSR), 1 ≤ PSR < GAINBITS
- DIVBITS, 16: ramp divider width
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- dat_i  in  DW  signed input sample, one per clock
- dat_o  out  DW  signed, rounded, saturated product
- addr  in  16  register address
- wen  in  1  write strobe, single cycle
- ren  in  1  read strobe, single cycle
- wdata  in  32  write data
- ack  out  1  access acknowledge
- rdata  out  32  read data

## Operation
- Registers, reset 0 unless stated:
  - 0x108 kp_target, r/w, GAINBITS signed.
  - 0x10C ramp_step, r/w, GAINBITS-1 unsigned.
  - 0x110 ramp_div, r/w, DIVBITS.
  - 0x114 status, r/o: bit0 = ramping.
  - 0x118 kp_cur, r/o.
  - 0x11C sat_count, r/o, 16 bits, saturates at 0xFFFF; any write clears it.
  - 0x200 = PSR, 0x20C = GAINBITS, 0x210 = DW, all r/o constants.
  - Any other address reads 0.
  - Write data is truncated to the field width; read data is zero-extended, except kp values, which are sign-extended.
- Ramp FSM, states IDLE and RAMP:
  - IDLE → RAMP when kp_cur ≠ kp_target and ramp_step ≠ 0. Entering RAMP loads div_cnt = ramp_div.
  - In RAMP, div_cnt decrements each cycle. At 0, kp_cur moves by ramp_step toward kp_target and div_cnt reloads.
  - If |kp_target − kp_cur| ≤ ramp_step, kp_cur takes kp_target and the FSM returns to IDLE.
  - The difference is computed in GAINBITS+1 bits, so it never overflows.
- ramp_step = 0 means immediate mode: kp_cur = kp_target one cycle after the target write. The FSM stays IDLE.
- Writing kp_target during RAMP retargets the ramp from the present kp_cur. div_cnt is not reloaded.
- Writing ramp_step or ramp_div takes effect at the next step or reload.
- status.ramping = (state == RAMP).
- Datapath:
  - prod = dat_i × kp_cur, DW+GAINBITS bits signed.
  - Round half up: r = (prod + 2^(PSR−1)) >>> PSR.
  - Saturate r to [−2^(DW−1), 2^(DW−1)−1].
  - sat_count increments by 1 on each cycle a clipped sample is produced.

## Timing
- Reset values: dat_o = 0, ack = 0, rdata = 0, all registers 0, FSM IDLE, div_cnt 0, pipeline cleared. Reset mid-ramp aborts the ramp immediately.
- Datapath latency is 3 cycles:
  1. Register dat_i and kp_cur.
  2. Register prod.
  3. Round, saturate, and register dat_o.
- A kp_cur change at edge t affects dat_o from edge t+3.
- Bus handshake:
  - ack rises the cycle after wen|ren for every address, including unmapped ones, and is high for one cycle.
  - rdata is valid while ack is high.
  - A register write lands on the edge that samples wen.
  - A read of a register in the same cycle as its write returns the old value.
- Ramp pacing:
  - kp_cur changes once every ramp_div+1 cycles.
  - The first change occurs ramp_div+1 cycles after the edge that enters RAMP.
  - RAMP is entered one cycle after the kp_target write.
- Simultaneous sat_count clear write and saturation event: the clear wins.

## Test plan
- Set kp_target = 0x1000, ramp_step = 0 (unity, immediate), dat_i = 1000 → dat_o = 1000 from 4 cycles after the write; status = 0.
- Set kp = 0x0800 (0.5): dat_i = 3 → dat_o = 2; dat_i = −3 → dat_o = −1 (round half up).
- Set kp = 0x4000 (4.0): dat_i = 8000 → dat_o = 8191; dat_i = −8192 → dat_o = −8192; sat_count counts every clipped cycle. Writing 0x11C → reads 0.
- From kp_cur = 0, set ramp_step = 0x100, ramp_div = 3, kp_target = 0x1000 → 16 steps of +0x100, each 4 cycles apart. kp_cur = 0x1000 and ramping clears about 65 cycles after the write. Read 0x118 mid-ramp to check monotonic progress.
- Mid-ramp at kp_cur = 0x800, write kp_target = 0x0400 → ramp reverses, kp_cur decreases by 0x100 per step, and the FSM ends IDLE at 0x400. Then set ramp_step = 0x300 with target 0x0500 → a single clamped step lands exactly on 0x500.
- Assert rstn_i mid-ramp, asynchronously between clock edges → dat_o, ack, and kp_cur are 0 immediately and status = 0. Read of an unmapped address 0x300 → ack pulses once, rdata = 0.
